// File: rtl/app_stream_pkg.sv
// Shared types for the app-side stream stages: word type and framing states.
package app_stream_pkg;

    localparam int WORD_W = 64;

    typedef logic [WORD_W-1:0] word_t;

    // Framing FSM: IDLE means the next pop starts a new frame.
    typedef enum logic {
        FR_IDLE     = 1'b0,
        FR_IN_FRAME = 1'b1
    } frame_state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO with one-cycle fill latency and no write-through.
module stream_fifo #(
    parameter int WIDTH     = 64,
    parameter int DEPTH_LOG = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]   mem [0:DEPTH-1];
    logic [DEPTH_LOG:0] wr_ptr;
    logic [DEPTH_LOG:0] rd_ptr;
    logic               ready_en;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
    assign full  = (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]) &&
                   (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // ready_en holds din_ready low through reset and for the release edge.
    assign in_ready  = ready_en && !full;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr[DEPTH_LOG-1:0]];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Storage array; data needs no reset since out_valid gates it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG-1:0]] <= in_data;
    end

    // Pointer and ready-enable state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/app_out_framer.sv
// Buffers the app word stream and marks every cfg_frame_words-th pop as last.
module app_out_framer
    import app_stream_pkg::*;
#(
    parameter int WORD_W    = app_stream_pkg::WORD_W,
    parameter int DEPTH_LOG = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [CNT_W-1:0]  cfg_frame_words,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last,
    input  logic              dout_ready,
    output logic [CNT_W-1:0]  frames_done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    frame_state_e     state_q, state_d;
    logic [CNT_W-1:0] beat_q,   beat_d;
    logic [CNT_W-1:0] len_q,    len_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic [CNT_W-1:0] eff_len;
    logic             pop;

    stream_fifo #(
        .WIDTH     (WORD_W),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (din),
        .in_valid  (din_valid),
        .in_ready  (din_ready),
        .out_data  (dout),
        .out_valid (dout_valid),
        .out_ready (dout_ready)
    );

    // A zero length would never terminate a frame, so it means one word.
    assign eff_len     = (cfg_frame_words == '0) ? ONE : cfg_frame_words;
    assign pop         = dout_valid && dout_ready;
    assign frames_done = frames_q;

    // Frame state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FR_IDLE;
            beat_q   <= '0;
            len_q    <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            frames_q <= frames_d;
        end
    end

    // Next-state and last flag; length is latched only on a frame's first pop.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        len_d     = len_q;
        frames_d  = frames_q;
        dout_last = 1'b0;
        case (state_q)
            FR_IDLE: begin
                dout_last = dout_valid && (eff_len == ONE);
                if (pop) begin
                    if (eff_len == ONE) begin
                        frames_d = frames_q + ONE;
                    end else begin
                        len_d   = eff_len;
                        beat_d  = ONE;
                        state_d = FR_IN_FRAME;
                    end
                end
            end
            FR_IN_FRAME: begin
                dout_last = dout_valid && (beat_q == len_q - ONE);
                if (pop) begin
                    if (beat_q == len_q - ONE) begin
                        beat_d   = '0;
                        frames_d = frames_q + ONE;
                        state_d  = FR_IDLE;
                    end else begin
                        beat_d = beat_q + ONE;
                    end
                end
            end
            default: state_d = FR_IDLE;
        endcase
    end

endmodule

// File: tb/tb_app_out_framer.sv
// Randomized self-checking bench for app_out_framer with a queue-based model.
module tb_app_out_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] cfg_frame_words = 16'd4;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        dout_ready = 1'b0;
    logic [15:0] frames_done;

    app_out_framer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .din             (din),
        .din_valid       (din_valid),
        .din_ready       (din_ready),
        .cfg_frame_words (cfg_frame_words),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_last       (dout_last),
        .dout_ready      (dout_ready),
        .frames_done     (frames_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: pending words, position within frame, latched length.
    logic [63:0] exp_q[$];
    int          pos;
    int          len;
    logic [15:0] m_frames;
    logic [15:0] next_cfg;

    // Per-cycle observations and expectations.
    logic        o_rdy, o_vld, o_last, e_rdy, e_vld, e_last;
    logic [63:0] o_dout, e_dout, prev_dout;
    logic [15:0] o_frames, e_frames;
    logic        push, pop, prev_stall, prev_last, stable_ok;

    task automatic model_clear();
        exp_q.delete();
        pos        = 0;
        len        = 1;
        m_frames   = '0;
        prev_stall = 1'b0;
    endtask

    // One clock: apply inputs at negedge, sample, then advance the model.
    task automatic cycle(input logic v, input logic [63:0] d, input logic r);
        int len_now;
        @(negedge clk);
        cfg_frame_words = next_cfg;
        din_valid  = v;
        din        = d;
        dout_ready = r;
        #1;
        o_rdy    = din_ready;
        o_vld    = dout_valid;
        o_dout   = dout;
        o_last   = dout_last;
        o_frames = frames_done;
        e_rdy    = exp_q.size() < 16;
        e_vld    = exp_q.size() != 0;
        e_dout   = e_vld ? exp_q[0] : 64'd0;
        len_now  = (pos == 0) ? ((next_cfg == 16'd0) ? 1 : int'(next_cfg)) : len;
        e_last   = e_vld && (pos == len_now - 1);
        e_frames = m_frames;
        stable_ok = !prev_stall || (o_dout === prev_dout && o_last === prev_last);
        push = v && o_rdy;
        pop  = o_vld && r;
        if (pop && e_vld) begin
            void'(exp_q.pop_front());
            if (pos == 0) len = len_now;
            pos++;
            if (pos == len) begin
                pos = 0;
                m_frames++;
            end
        end
        if (push) exp_q.push_back(d);
        prev_stall = o_vld && !r;
        prev_dout  = o_dout;
        prev_last  = o_last;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        dout_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (dout_valid !== 1'b0 || dout_last !== 1'b0 || din_ready !== 1'b0 || frames_done !== 16'd0) begin
            n_err++;
            $display("FAIL reset: vld=%b last=%b rdy=%b frames=%0d required 0 0 0 0",
                     dout_valid, dout_last, din_ready, frames_done);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 64'd0, 1'b0);
        n_chk++;
        if (o_rdy !== 1'b1 || o_vld !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b vld=%b required 1 0", o_rdy, o_vld);
        end
    endtask

    // cfg=4, 8 words streamed straight through.
    task automatic test_basic();
        int k = 0;
        do_reset();
        next_cfg = 16'd4;
        for (int i = 0; i < 40 && k < 8; i++) begin
            cycle(i < 8, 64'(i < 8 ? i : 0), 1'b1);
            n_chk++;
            if (o_vld !== e_vld || o_rdy !== e_rdy || (e_vld && (o_dout !== e_dout || o_last !== e_last))) begin
                n_err++;
                $display("FAIL basic: vld=%b dout=%0h last=%b required vld=%b dout=%0h last=%b",
                         o_vld, o_dout, o_last, e_vld, e_dout, e_last);
            end
            if (pop) begin
                n_chk++;
                if (o_dout !== 64'(k) || o_last !== (k == 3 || k == 7)) begin
                    n_err++;
                    $display("FAIL basic_order: word %0d dout=%0h last=%b", k, o_dout, o_last);
                end
                k++;
            end
        end
        cycle(1'b0, 64'd0, 1'b1);
        n_chk++;
        if (k != 8 || o_frames !== 16'd2) begin
            n_err++;
            $display("FAIL basic_frames: pops=%0d frames=%0d required 8 2", k, o_frames);
        end
    endtask

    // Fill to full with the sink stalled, then drain all 17.
    task automatic test_full();
        int acc = 0;
        int k = 0;
        do_reset();
        next_cfg = 16'd4;
        for (int i = 0; i < 22 && acc < 17; i++) begin
            cycle(1'b1, 64'(100 + acc), 1'b0);
            if (push) acc++;
        end
        n_chk++;
        if (acc != 16 || o_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL full_stall: accepted=%0d rdy=%b required 16 0", acc, o_rdy);
        end
        for (int i = 0; i < 60 && k < 17; i++) begin
            cycle(acc < 17, 64'(100 + acc), 1'b1);
            if (push) acc++;
            n_chk++;
            if (o_vld !== e_vld || o_rdy !== e_rdy || (e_vld && (o_dout !== e_dout || o_last !== e_last))) begin
                n_err++;
                $display("FAIL full_drain: dout=%0h last=%b rdy=%b required dout=%0h last=%b rdy=%b",
                         o_dout, o_last, o_rdy, e_dout, e_last, e_rdy);
            end
            if (pop) begin
                n_chk++;
                if (o_dout !== 64'(100 + k)) begin
                    n_err++;
                    $display("FAIL full_order: got %0d required %0d", o_dout, 100 + k);
                end
                k++;
            end
        end
        n_chk++;
        if (k != 17) begin
            n_err++;
            $display("FAIL full_count: popped %0d required 17", k);
        end
    endtask

    // cfg=0 behaves as one-word frames.
    task automatic test_len_zero();
        int k = 0;
        do_reset();
        next_cfg = 16'd0;
        for (int i = 0; i < 30 && k < 5; i++) begin
            cycle(i < 5, 64'(50 + i), 1'b1);
            if (pop) begin
                n_chk++;
                if (o_last !== 1'b1 || o_dout !== e_dout) begin
                    n_err++;
                    $display("FAIL len0: dout=%0h last=%b required dout=%0h last=1", o_dout, o_last, e_dout);
                end
                k++;
            end
        end
        cycle(1'b0, 64'd0, 1'b0);
        n_chk++;
        if (o_frames !== 16'd5) begin
            n_err++;
            $display("FAIL len0_frames: frames=%0d required 5", o_frames);
        end
    endtask

    // Length change mid-frame applies to the following frame only.
    task automatic test_cfg_change();
        int k = 0;
        do_reset();
        next_cfg = 16'd3;
        for (int i = 0; i < 6; i++) cycle(1'b1, 64'(200 + i), 1'b0);
        for (int i = 0; i < 20 && k < 6; i++) begin
            cycle(1'b0, 64'd0, 1'b1);
            if (pop) begin
                n_chk++;
                if (o_dout !== 64'(200 + k) || o_last !== (k == 2 || k == 4) || o_last !== e_last) begin
                    n_err++;
                    $display("FAIL cfg_change: word %0d dout=%0h last=%b model_last=%b", k, o_dout, o_last, e_last);
                end
                k++;
            end
            next_cfg = 16'd2;
        end
    endtask

    // Random valid/ready with stall-stability and scoreboard checks.
    task automatic test_random();
        int sent = 0;
        int rcvd = 0;
        logic [63:0] cur;
        do_reset();
        next_cfg = 16'd3;
        cur = {$urandom, $urandom};
        for (int i = 0; i < 20000 && rcvd < 1000; i++) begin
            cycle(sent < 1000 && $urandom_range(0, 9) < 7, cur, $urandom_range(0, 9) < 6);
            if (push) begin
                sent++;
                cur = {$urandom, $urandom};
            end
            if (pop) rcvd++;
            n_chk++;
            if (o_vld !== e_vld || o_rdy !== e_rdy || o_frames !== e_frames || !stable_ok ||
                (e_vld && (o_dout !== e_dout || o_last !== e_last))) begin
                n_err++;
                $display("FAIL random: vld=%b rdy=%b dout=%0h last=%b frames=%0d stable=%b required vld=%b rdy=%b dout=%0h last=%b frames=%0d",
                         o_vld, o_rdy, o_dout, o_last, o_frames, stable_ok, e_vld, e_rdy, e_dout, e_last, e_frames);
            end
            if (pos != 0 && $urandom_range(0, 15) == 0) next_cfg = 16'($urandom_range(0, 5));
        end
        n_chk++;
        if (rcvd != 1000) begin
            n_err++;
            $display("FAIL random_timeout: received %0d required 1000", rcvd);
        end
    endtask

    // Async reset mid-frame drops buffered words and the partial frame.
    task automatic test_reset_mid();
        int k = 0;
        do_reset();
        next_cfg = 16'd4;
        for (int i = 0; i < 11; i++) cycle(1'b1, 64'(300 + i), 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 64'd0, 1'b1);
        cycle(1'b0, 64'd0, 1'b0);
        n_chk++;
        if (o_frames !== 16'd1 || o_vld !== 1'b1 || exp_q.size() != 5) begin
            n_err++;
            $display("FAIL mid_setup: frames=%0d vld=%b buffered=%0d required 1 1 5", o_frames, o_vld, exp_q.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (dout_valid !== 1'b0 || frames_done !== 16'd0 || dout_last !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: vld=%b frames=%0d last=%b required 0 0 0", dout_valid, frames_done, dout_last);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 64'd0, 1'b1);
            n_chk++;
            if (o_vld !== 1'b0) begin
                n_err++;
                $display("FAIL mid_stale: vld=%b dout=%0h required vld=0", o_vld, o_dout);
            end
        end
        for (int i = 0; i < 8 && k < 1; i++) begin
            cycle(i == 0, 64'hABC, 1'b1);
            n_chk++;
            if (o_vld !== e_vld || (e_vld && (o_dout !== e_dout || o_last !== e_last))) begin
                n_err++;
                $display("FAIL mid_new: vld=%b dout=%0h last=%b required vld=%b dout=%0h last=%b",
                         o_vld, o_dout, o_last, e_vld, e_dout, e_last);
            end
            if (pop) k++;
        end
        n_chk++;
        if (k != 1) begin
            n_err++;
            $display("FAIL mid_new_count: popped %0d required 1", k);
        end
    endtask

    initial begin
        next_cfg = 16'd4;
        model_clear();
        test_reset();
        test_basic();
        test_full();
        test_len_zero();
        test_cfg_change();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
